// File: rtl/mix_columns_arbiter_pkg.sv
// Shared AES definitions for the column-serial MixColumns arbiter: state/column
// types, GF(2^8) reduction constant, FSM encoding and column helpers.
package mix_columns_arbiter_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  column_t;

  localparam logic [7:0] GF_POLY  = 8'h1B;
  localparam int         NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } fsm_e;

  typedef enum logic {
    DIR_ENC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  // Column 0 occupies the most significant word of the state.
  function automatic column_t get_column(input state_t s, input logic [1:0] idx);
    column_t c;
    case (idx)
      2'd0:    c = s[127:96];
      2'd1:    c = s[95:64];
      2'd2:    c = s[63:32];
      default: c = s[31:0];
    endcase
    return c;
  endfunction

  function automatic state_t set_column(input state_t s, input logic [1:0] idx,
                                        input column_t c);
    state_t r;
    r = s;
    case (idx)
      2'd0:    r[127:96] = c;
      2'd1:    r[95:64]  = c;
      2'd2:    r[63:32]  = c;
      default: r[31:0]   = c;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_arbiter_mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns over GF(2^8), 0x11B.
module mix_column_unit
  import mix_columns_arbiter_pkg::*;
(
  input  column_t col_i,
  input  logic    inverse_i,
  output column_t col_o
);

  logic [7:0] a   [NUM_COLS];
  logic [7:0] x2  [NUM_COLS];
  logic [7:0] x4  [NUM_COLS];
  logic [7:0] x8  [NUM_COLS];
  logic [7:0] m9  [NUM_COLS];
  logic [7:0] mb  [NUM_COLS];
  logic [7:0] md  [NUM_COLS];
  logic [7:0] me  [NUM_COLS];
  logic [7:0] fwd [NUM_COLS];
  logic [7:0] inv [NUM_COLS];

  assign a[0] = col_i[31:24];
  assign a[1] = col_i[23:16];
  assign a[2] = col_i[15:8];
  assign a[3] = col_i[7:0];

  for (genvar g = 0; g < NUM_COLS; g++) begin : g_byte
    assign x2[g] = xtime(a[g]);
    assign x4[g] = xtime(x2[g]);
    assign x8[g] = xtime(x4[g]);
    assign m9[g] = x8[g] ^ a[g];
    assign mb[g] = x8[g] ^ x2[g] ^ a[g];
    assign md[g] = x8[g] ^ x4[g] ^ a[g];
    assign me[g] = x8[g] ^ x4[g] ^ x2[g];
    // Row g of the circulant matrix starts its coefficient pattern at byte g.
    assign fwd[g] = x2[g] ^ x2[(g+1)%4] ^ a[(g+1)%4] ^ a[(g+2)%4] ^ a[(g+3)%4];
    assign inv[g] = me[g] ^ mb[(g+1)%4] ^ md[(g+2)%4] ^ m9[(g+3)%4];
  end

  assign col_o = inverse_i ? {inv[0], inv[1], inv[2], inv[3]}
                           : {fwd[0], fwd[1], fwd[2], fwd[3]};

endmodule

// File: rtl/mix_columns_arbiter.sv
// Arbitrates encrypt/decrypt requests onto one column-serial MixColumns unit.
// Define MIX_COLUMNS_ROUND_ROBIN_EN for round-robin; otherwise encrypt has fixed priority.
module mix_columns_arbiter
  import mix_columns_arbiter_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   enc_valid,
  output logic   enc_ready,
  input  state_t enc_state,
  input  logic   dec_valid,
  output logic   dec_ready,
  input  state_t dec_state,
  output logic   rsp_valid,
  input  logic   rsp_ready,
  output state_t rsp_state,
  output logic   rsp_inverse,
  output logic   busy
);

  fsm_e       state_q, state_d;
  state_t     work_q,  work_d;
  dir_e       dir_q,   dir_d;
  logic [1:0] col_q,   col_d;

  logic    grant_enc, grant_dec, accept;
  column_t col_in, col_out;

`ifdef MIX_COLUMNS_ROUND_ROBIN_EN
  dir_e last_grant_q;

  // Encrypt wins a tie only when decrypt was served last.
  assign grant_enc = enc_valid & (~dec_valid | (last_grant_q == DIR_DEC));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= DIR_DEC;
    end else if (accept) begin
      last_grant_q <= grant_enc ? DIR_ENC : DIR_DEC;
    end
  end
`else
  assign grant_enc = enc_valid;
`endif

  assign grant_dec = dec_valid & ~grant_enc;
  assign accept    = (state_q == ST_IDLE) & (grant_enc | grant_dec);
  assign enc_ready = (state_q == ST_IDLE) & grant_enc;
  assign dec_ready = (state_q == ST_IDLE) & grant_dec;

  assign col_in = get_column(work_q, col_q);

  mix_column_unit u_mix_column_unit (
    .col_i     (col_in),
    .inverse_i (dir_q == DIR_DEC),
    .col_o     (col_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          work_d  = grant_enc ? enc_state : dec_state;
          dir_d   = grant_enc ? DIR_ENC : DIR_DEC;
          col_d   = 2'd0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        work_d = set_column(work_q, col_q, col_out);
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      dir_q   <= DIR_ENC;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      col_q   <= col_d;
    end
  end

  // Response fields are gated so partial column results never leak out.
  assign rsp_valid   = (state_q == ST_DONE);
  assign rsp_state   = rsp_valid ? work_q : '0;
  assign rsp_inverse = rsp_valid & (dir_q == DIR_DEC);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/mix_columns_arbiter.md
# mix_columns_arbiter

Shares one column-serial MixColumns / InvMixColumns datapath between an encrypt requester and a decrypt requester in the AES processor. Each accepted request carries a full 128-bit state. The block transforms it one 32-bit column per cycle over four cycles, then returns the result with a valid/ready handshake tagged with the direction. It replaces two full-width combinational MixColumns instances where area matters more than throughput.

## Interface
- No parameters; widths fixed by the AES state (128 bits, 4 columns x 32 bits).
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enc_valid  in  1  encrypt requester has a state
- enc_ready  out  1  encrypt request accepted this cycle
- enc_state  in  128  state for forward MixColumns
- dec_valid  in  1  decrypt requester has a state
- dec_ready  out  1  decrypt request accepted this cycle
- dec_state  in  128  state for InvMixColumns
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_state  out  128  transformed state
- rsp_inverse  out  1  1 = result of InvMixColumns (decrypt), 0 = forward
- busy  out  1  high in any state other than IDLE

## Operation
- State layout: byte 0 = bits [127:120]; column c = bits [127-32c : 96-32c].
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - If either valid is high, grant one requester.
  - Assert only that requester's ready for the cycle.
  - Latch its state into the work register and latch the direction.
  - Clear the column counter and go to COMPUTE.
- COMPUTE:
  - Column counter 2 bits, values 0..3.
  - Each cycle, column[counter] of the work register goes through the datapath in the latched direction and is written back in place.
  - When the counter reaches 3, wrap it to 0 and go to DONE.
- DONE:
  - rsp_valid = 1; rsp_state = work register; rsp_inverse = latched direction.
  - Hold all three stable until rsp_ready = 1, then go to IDLE.
  - rsp_ready is ignored outside DONE.
- Arbitration, round-robin: the last_grant register resets to "decrypt", so encrypt wins the first contention. When both valids are high, grant the requester not in last_grant. A lone requester is always granted.
- Requests are never accepted outside IDLE; ready is low in COMPUTE and DONE.
- Datapath arithmetic is GF(2^8) with reduction polynomial 0x11B:
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
  - Forward matrix rows: 02 03 01 01, rotated.
  - Inverse matrix rows: 0E 0B 0D 09, rotated.

## Timing
- Reset values: enc_ready = 0, dec_ready = 0, rsp_valid = 0, rsp_state = 0, rsp_inverse = 0, busy = 0; FSM = IDLE; last_grant = decrypt; work register = 0.
- Latency: request accepted on edge N; columns 0..3 are written on edges N+1..N+4; rsp_valid is high after edge N+4.
- Earliest next accept is the cycle after the response handshake edge. Minimum period is 6 cycles per state.
- Ready is combinational from FSM state, arbitration and the valids. A requester may drop valid at any time before it is granted.
- Reset asserted mid-operation immediately aborts the request. The in-flight state is discarded and never returned.

## Configuration
- MIX_COLUMNS_ROUND_ROBIN_EN:
  - Defined: round-robin as above.
  - Undefined: fixed priority, encrypt always wins a tie, and the last_grant register is not instantiated.
  - All other behaviour is identical in both builds.

## Structure
- Shared AES definitions package holds:
  - state_t (128-bit) and column_t (32-bit) typedefs.
  - GF_POLY = 8'h1B.
  - FSM state enum.
  - Column index / extract helper function.
- One sub-module, mix_column_unit: combinational, one 32-bit column, inverse select input, forward and inverse math.
- This module owns the FSM, arbiter, counter and work register.

## Test plan
- Forward: enc_state d4bf5d30e0b452aeb84111f11e2798e5 -> rsp_state 046681e5e0cb199a48f8d37a2806264c, rsp_inverse = 0, rsp_valid exactly 4 edges after accept.
- Inverse: dec_state 046681e5e0cb199a48f8d37a2806264c -> rsp_state d4bf5d30e0b452aeb84111f11e2798e5, rsp_inverse = 1.
- Identity column: 01010101 repeated in all four columns -> unchanged output in both directions.
- Contention: enc_valid and dec_valid both held high with rsp_ready = 1 -> grant order enc, dec, enc, dec with round-robin; enc every time with the macro undefined.
- Backpressure: rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_state, rsp_inverse stable, both ready outputs low; after rsp_ready = 1, return to IDLE and accept the next request the following cycle.
- Reset mid-COMPUTE (after 2 columns): all outputs 0 and busy = 0 immediately; a new request afterwards completes correctly and encrypt wins the first contention.
